// File: rtl/lfsr_stream_scrambler.sv
// Additive stream scrambler/descrambler: Fibonacci LFSR with runtime tap mask,
// DATA_W keystream bits per word, one valid/ready output register stage.
module lfsr_stream_scrambler #(
    parameter int unsigned             DATA_W     = 32,
    parameter int unsigned             LFSR_W     = 32,
    parameter logic [LFSR_W-1:0]       LFSR_RESET = LFSR_W'(1),
    parameter int unsigned             CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [LFSR_W-1:0] poly_mask,
    input  logic              enable,
    input  logic [LFSR_W-1:0] seed_value,
    input  logic              seed_load,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              lockup_err,
    output logic [CNT_W-1:0]  word_count
);

    logic [LFSR_W-1:0] state_q, state_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              lockup_q, lockup_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              accept;
    logic              use_s0;
    logic              lock;
    logic [LFSR_W-1:0] s0_raw;
    logic [LFSR_W-1:0] s0;
    logic [LFSR_W-1:0] s_end;
    logic [DATA_W-1:0] keystream;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign use_s0   = accept || seed_load;
    assign s0_raw   = seed_load ? seed_value : state_q;
    // An all-zero start state would lock the LFSR forever; substitute the reset state.
    assign lock     = use_s0 && (s0_raw == '0);
    assign s0       = lock ? LFSR_RESET : s0_raw;

    always_comb begin
        s_end = s0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            s_end = {s_end[LFSR_W-2:0], ^(s_end & poly_mask)};
        end
    end

    assign keystream = s_end[DATA_W-1:0];

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        lockup_d    = lockup_q;
        cnt_d       = cnt_q;

        if (accept && enable) begin
            state_d = s_end;
        end else if (use_s0) begin
            // Seed load without scrambling, or lock-up recovery on a bypass word.
            state_d = s0;
        end

        if (seed_load) begin
            cnt_d = (accept && enable) ? CNT_W'(1) : '0;
        end else if (accept && enable && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (lock) begin
            lockup_d = 1'b1;
        end else if (seed_load && (seed_value != '0)) begin
            lockup_d = 1'b0;
        end

        if (accept) begin
            out_data_d  = enable ? (in_data ^ keystream) : in_data;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= LFSR_RESET;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            lockup_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            lockup_q    <= lockup_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign lockup_err = lockup_q;
    assign word_count = cnt_q;

endmodule

// File: tb/tb_lfsr_stream_scrambler.sv
// Self-checking bench: directed vectors, stall/seed/lock-up/reset sequences, and a
// random scramble->descramble loop checked against an arithmetic keystream model.
module tb_lfsr_stream_scrambler;

    localparam int DW = 8;
    localparam int LW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [LW-1:0] poly_mask = 32'h48;
    logic          enable = 1'b1;
    logic [LW-1:0] seed_value = '0;
    logic          seed_load = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          scr_out_ready;
    logic          lockup_err;
    logic [CW-1:0] word_count;

    logic          loop_mode = 1'b0;
    logic          tb_ready = 1'b1;
    logic          ds_ready = 1'b1;
    logic          des_in_valid;
    logic          des_in_ready;
    logic [DW-1:0] des_out_data;
    logic          des_out_valid;
    logic          des_lockup;
    logic [CW-1:0] des_word_count;
    logic          des_seed_load = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    assign scr_out_ready = loop_mode ? des_in_ready : tb_ready;
    assign des_in_valid  = loop_mode && out_valid;

    always #5 clk = ~clk;

    lfsr_stream_scrambler #(.DATA_W(DW), .LFSR_W(LW), .LFSR_RESET(32'd1), .CNT_W(CW)) u_scr (
        .clk(clk), .reset_n(reset_n), .poly_mask(poly_mask), .enable(enable),
        .seed_value(seed_value), .seed_load(seed_load),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(scr_out_ready),
        .lockup_err(lockup_err), .word_count(word_count)
    );

    lfsr_stream_scrambler #(.DATA_W(DW), .LFSR_W(LW), .LFSR_RESET(32'd1), .CNT_W(CW)) u_des (
        .clk(clk), .reset_n(reset_n), .poly_mask(poly_mask), .enable(enable),
        .seed_value(seed_value), .seed_load(des_seed_load),
        .in_data(out_data), .in_valid(des_in_valid), .in_ready(des_in_ready),
        .out_data(des_out_data), .out_valid(des_out_valid), .out_ready(ds_ready),
        .lockup_err(des_lockup), .word_count(des_word_count)
    );

    // Keystream model: n feedback bits, each the parity of the tapped state bits.
    function automatic logic [31:0] advance(logic [31:0] s, logic [31:0] m, int n);
        for (int k = 0; k < n; k++) begin
            s = (s << 1) | 32'($countones(s & m) % 2);
        end
        return s;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        seed_load = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Presents one word (optionally with a seed strobe) for one edge, then samples.
    task automatic send(logic [DW-1:0] din, logic en, logic sl, logic [LW-1:0] sv);
        in_data    = din;
        enable     = en;
        in_valid   = 1'b1;
        seed_load  = sl;
        seed_value = sv;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        seed_load = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic          rst;
        logic          en;
        logic [DW-1:0] din;
        logic [DW-1:0] exp_out;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [31:0] mstate;
        logic [DW-1:0] sq[$];
        logic [DW-1:0] oq[$];
        logic [DW-1:0] d, e;
        int n_sent, n_rx;

        vecs[0] = '{1'b1, 1'b1, 8'h00, 8'h13, 16'd1};
        vecs[1] = '{1'b1, 1'b1, 8'hFF, 8'hEC, 16'd1};
        vecs[2] = '{1'b1, 1'b0, 8'hA5, 8'hA5, 16'd0};
        vecs[3] = '{1'b0, 1'b1, 8'h00, 8'h13, 16'd1};
        vecs[4] = '{1'b0, 1'b0, 8'h5A, 8'h5A, 16'd1};

        do_reset();
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_lockup", 64'(lockup_err), 64'd0);
        check("rst_count", 64'(word_count), 64'd0);
        check("rst_state", 64'(u_scr.state_q), 64'd1);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            send(vecs[i].din, vecs[i].en, 1'b0, '0);
            check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("vec%0d_data", i), 64'(out_data), 64'(vecs[i].exp_out));
            check($sformatf("vec%0d_count", i), 64'(word_count), 64'(vecs[i].exp_cnt));
        end
        do_reset();
        send(8'h00, 1'b1, 1'b0, '0);
        check("first_state", 64'(u_scr.state_q), 64'h113);

        // Backpressure: word held, state frozen, then resumes from 0x113.
        do_reset();
        tb_ready = 1'b0;
        send(8'h00, 1'b1, 1'b0, '0);
        in_data  = 8'h77;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_data", 64'(out_data), 64'h13);
            check("stall_state", 64'(u_scr.state_q), 64'h113);
        end
        tb_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        mstate = advance(32'h113, 32'h48, DW);
        check("release_data", 64'(out_data), 64'(8'h77 ^ mstate[7:0]));
        check("release_state", 64'(u_scr.state_q), 64'(mstate));
        check("release_count", 64'(word_count), 64'd2);

        // Seed in the same cycle as an accepted word.
        do_reset();
        for (int w = 0; w < 10; w++) send(DW'($urandom), 1'b1, 1'b0, '0);
        check("pre_seed_count", 64'(word_count), 64'd10);
        send(8'h00, 1'b1, 1'b1, 32'd1);
        check("seed_acc_data", 64'(out_data), 64'h13);
        check("seed_acc_count", 64'(word_count), 64'd1);

        // Zero seed triggers lock-up recovery; a non-zero seed clears the flag.
        seed_value = '0;
        seed_load  = 1'b1;
        @(posedge clk);
        #1 seed_load = 1'b0;
        @(negedge clk);
        check("zseed_lockup", 64'(lockup_err), 64'd1);
        check("zseed_state", 64'(u_scr.state_q), 64'd1);
        check("zseed_count", 64'(word_count), 64'd0);
        send(8'h00, 1'b1, 1'b0, '0);
        check("zseed_data", 64'(out_data), 64'h13);
        check("zseed_sticky", 64'(lockup_err), 64'd1);
        seed_value = 32'd5;
        seed_load  = 1'b1;
        @(posedge clk);
        #1 seed_load = 1'b0;
        @(negedge clk);
        check("seed5_lockup", 64'(lockup_err), 64'd0);
        check("seed5_state", 64'(u_scr.state_q), 64'd5);

        // Asynchronous reset drops a pending word immediately.
        tb_ready = 1'b0;
        send(8'h3C, 1'b1, 1'b0, '0);
        check("pend_valid", 64'(out_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_valid", 64'(out_valid), 64'd0);
        check("async_state", 64'(u_scr.state_q), 64'd1);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tb_ready = 1'b1;

        // Random loop-through: scrambler feeds descrambler, compare both ends.
        do_reset();
        loop_mode = 1'b1;
        enable    = 1'b1;
        mstate    = 32'd1;
        n_sent    = 0;
        n_rx      = 0;
        for (int cyc = 0; cyc < 20000 && n_rx < 1000; cyc++) begin
            @(negedge clk);
            in_valid = (n_sent < 1000) && ($urandom_range(3) != 0);
            in_data  = DW'($urandom);
            ds_ready = ($urandom_range(3) != 0);
            #1;
            if (in_valid && in_ready) begin
                mstate = advance(mstate, 32'h48, DW);
                sq.push_back(in_data ^ mstate[7:0]);
                oq.push_back(in_data);
                n_sent++;
            end
            if (out_valid && des_in_ready) begin
                e = (sq.size() > 0) ? sq.pop_front() : 8'hxx;
                check("rand_scr", 64'(out_data), 64'(e));
            end
            if (des_out_valid && ds_ready) begin
                d = (oq.size() > 0) ? oq.pop_front() : 8'hxx;
                check("rand_des", 64'(des_out_data), 64'(d));
                n_rx++;
            end
        end
        in_valid = 1'b0;
        check("rand_rx_done", 64'(n_rx), 64'd1000);
        check("rand_scr_count", 64'(word_count), 64'd1000);
        check("rand_des_count", 64'(des_word_count), 64'd1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
